exec_nlane: RTL and testbench

Parametrised N-lane execute stage, successor to the dual-issue execute stage. It sits between register read/forwarding and memory access. Each cycle it accepts one bundle of LANES instructions, runs a per-lane ALU, and registers results, destinations and a load flag for the memory stage. It adds a wider ALU op set and an optional iterative multiplier that stalls upstream through `ex_busy`.

---
 rtl/exec_nlane_pkg.sv | 58 +++++
 rtl/exec_nlane_mul_iter.sv | 36 +++
 rtl/exec_nlane.sv | 176 +++++++++++++++++
 tb/tb_exec_nlane.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/exec_nlane_pkg.sv
// exec_pkg: op encoding, pipeline constants and the per-lane ALU shared by exec_nlane.
// The ALU works on a 64-bit container and masks to the caller's XLEN (XLEN <= 64).
package exec_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_SRL  = 4'd3,
    OP_SLL  = 4'd4,
    OP_SRA  = 4'd5,
    OP_AND  = 4'd6,
    OP_OR   = 4'd7,
    OP_XOR  = 4'd8,
    OP_SLT  = 4'd9,
    OP_SLTU = 4'd10,
    OP_MUL  = 4'd11
  } exec_type_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } exec_state_e;

  localparam logic [5:0] LOAD_OPCODE = 6'b010000;
  localparam logic [2:0] BUBBLE_HDR  = 3'b111;
  localparam int         ALU_MAXW    = 64;

  // MUL is handled by the iterative multiplier, so here it falls into the srcb default.
  function automatic logic [ALU_MAXW-1:0] exec_alu(input logic [ALU_MAXW-1:0] srca,
                                                   input logic [ALU_MAXW-1:0] srcb,
                                                   input logic [3:0]          op,
                                                   input int                  xlen);
    logic [ALU_MAXW-1:0] mask, a_u, b_u, a_s, b_s, res;
    int                  shamt;
    mask  = {ALU_MAXW{1'b1}} >> (ALU_MAXW - xlen);
    a_u   = srca & mask;
    b_u   = srcb & mask;
    a_s   = a_u[xlen-1] ? (a_u | ~mask) : a_u;
    b_s   = b_u[xlen-1] ? (b_u | ~mask) : b_u;
    shamt = int'(b_u[5:0]) & ((1 << $clog2(xlen)) - 1);
    case (op)
      OP_ADD:  res = a_u + b_u;
      OP_SUB:  res = a_u - b_u;
      OP_SRL:  res = a_u >> shamt;
      OP_SLL:  res = a_u << shamt;
      OP_SRA:  res = $unsigned($signed(a_s) >>> shamt);
      OP_AND:  res = a_u & b_u;
      OP_OR:   res = a_u | b_u;
      OP_XOR:  res = a_u ^ b_u;
      OP_SLT:  res = {{(ALU_MAXW-1){1'b0}}, $signed(a_s) < $signed(b_s)};
      OP_SLTU: res = {{(ALU_MAXW-1){1'b0}}, a_u < b_u};
      default: res = b_u;
    endcase
    return res & mask;
  endfunction

endpackage

// File: rtl/exec_nlane_mul_iter.sv
// exec_mul_iter: radix-2 shift-add multiplier, one iteration per clock after start.
// The iteration count is owned by the parent; extra iterations are harmless once the multiplier drains to zero.
module exec_mul_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  input  logic [XLEN-1:0] multiplicand,
  input  logic [XLEN-1:0] multiplier,
  output logic [XLEN-1:0] product
);

  logic [XLEN-1:0] acc, mcand, mplier;

  // Accumulator value after the iteration in flight, so the final edge can register it directly.
  assign product = mplier[0] ? acc + mcand : acc;

  // NOTE: state updates use <= so every register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start) begin
      acc    <= '0;
      mcand  <= multiplicand;
      mplier <= multiplier;
    end else begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

endmodule

// File: rtl/exec_nlane.sv
// exec_nlane: N-lane execute stage with per-lane ALU and registered outputs to the memory stage.
// Define EXEC_NLANE_MUL_EN to add the iterative MUL op, its IDLE/MUL FSM and the ex_busy stall.
module exec_nlane
  import exec_pkg::*;
#(
  parameter int LANES = 2,
  parameter int XLEN  = 32,
  parameter int IW    = 32,
  parameter int RW    = 5
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  interlock,
  output logic                  ex_busy,
  input  logic [31:0]           pc,
  input  logic [LANES*IW-1:0]   inst,
  input  logic [LANES*XLEN-1:0] srca,
  input  logic [LANES*XLEN-1:0] srcb,
  input  logic [LANES*4-1:0]    e_type,
  input  logic [LANES*RW-1:0]   rt,
  input  logic [LANES-1:0]      rt_flag,
  output logic [31:0]           pc_to_the_next,
  output logic [LANES*IW-1:0]   inst_to_the_next,
  output logic [LANES*XLEN-1:0] tdata,
  output logic [LANES*RW-1:0]   rt_to_the_next,
  output logic [LANES-1:0]      rt_flag_to_the_next,
  output logic                  ex_to_mem_ready
);

  localparam logic [IW-1:0]       BUBBLE_INST   = {BUBBLE_HDR, {(IW-3){1'b0}}};
  localparam logic [LANES*IW-1:0] BUBBLE_BUNDLE = {LANES{BUBBLE_INST}};

  logic [LANES*XLEN-1:0] alu_res;
  logic [LANES-1:0]      is_load;

`ifdef EXEC_NLANE_MUL_EN
  localparam int CW = $clog2(XLEN + 1);

  exec_state_e           state;
  logic [CW-1:0]         cnt;
  logic [LANES-1:0]      is_mul;
  logic [LANES*XLEN-1:0] mul_prod;
  logic [LANES*XLEN-1:0] final_res;
  logic                  accept;
  logic [31:0]           pc_l;
  logic [LANES*IW-1:0]   inst_l;
  logic [LANES*RW-1:0]   rt_l;
  logic [LANES-1:0]      rt_flag_l;
  logic [LANES-1:0]      mul_l;
  logic                  load_l;
  logic [LANES*XLEN-1:0] res_l;

  assign accept  = (state == S_IDLE) && !interlock;
  assign ex_busy = (state == S_MUL);
`else
  assign ex_busy = 1'b0;
`endif

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [ALU_MAXW-1:0] a_ext, b_ext, r_ext;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
      a_ext = '0;
      b_ext = '0;
      a_ext[XLEN-1:0] = srca[i*XLEN +: XLEN];
      b_ext[XLEN-1:0] = srcb[i*XLEN +: XLEN];
      r_ext = exec_alu(a_ext, b_ext, e_type[i*4 +: 4], XLEN);
    end

    assign alu_res[i*XLEN +: XLEN] = r_ext[XLEN-1:0];
    assign is_load[i] = (inst[i*IW + IW-6 +: 6] == LOAD_OPCODE);

    if (XLEN < ALU_MAXW) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^r_ext[ALU_MAXW-1:XLEN];
    end

`ifdef EXEC_NLANE_MUL_EN
    assign is_mul[i] = (e_type[i*4 +: 4] == OP_MUL);
    assign final_res[i*XLEN +: XLEN] = mul_l[i] ? mul_prod[i*XLEN +: XLEN] : res_l[i*XLEN +: XLEN];

    exec_mul_iter #(.XLEN(XLEN)) u_mul (
      .clk          (clk),
      .rstn         (rstn),
      .start        (accept && is_mul[i]),
      .multiplicand (srca[i*XLEN +: XLEN]),
      .multiplier   (srcb[i*XLEN +: XLEN]),
      .product      (mul_prod[i*XLEN +: XLEN])
    );
`endif
  end

`ifdef EXEC_NLANE_MUL_EN
  // NOTE: the latched bundle (pc_l..res_l) is only read after being written on acceptance, so it carries no reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state               <= S_IDLE;
      cnt                 <= '0;
      pc_to_the_next      <= '0;
      inst_to_the_next    <= BUBBLE_BUNDLE;
      tdata               <= '0;
      rt_to_the_next      <= '0;
      rt_flag_to_the_next <= '0;
      ex_to_mem_ready     <= 1'b0;
    end else begin
      // Bubble unless a bundle is emitted below; tdata and rt hold.
      pc_to_the_next      <= '0;
      inst_to_the_next    <= BUBBLE_BUNDLE;
      rt_flag_to_the_next <= '0;
      ex_to_mem_ready     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!interlock) begin
            if (|is_mul) begin
              pc_l      <= pc;
              inst_l    <= inst;
              rt_l      <= rt;
              rt_flag_l <= rt_flag;
              load_l    <= |is_load;
              mul_l     <= is_mul;
              res_l     <= alu_res;
              cnt       <= CW'(XLEN);
              state     <= S_MUL;
            end else begin
              pc_to_the_next      <= pc;
              inst_to_the_next    <= inst;
              tdata               <= alu_res;
              rt_to_the_next      <= rt;
              rt_flag_to_the_next <= rt_flag;
              ex_to_mem_ready     <= |is_load;
            end
          end
        end
        S_MUL: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            pc_to_the_next      <= pc_l;
            inst_to_the_next    <= inst_l;
            tdata               <= final_res;
            rt_to_the_next      <= rt_l;
            rt_flag_to_the_next <= rt_flag_l;
            ex_to_mem_ready     <= load_l;
            state               <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pc_to_the_next      <= '0;
      inst_to_the_next    <= BUBBLE_BUNDLE;
      tdata               <= '0;
      rt_to_the_next      <= '0;
      rt_flag_to_the_next <= '0;
      ex_to_mem_ready     <= 1'b0;
    end else if (interlock) begin
      pc_to_the_next      <= '0;
      inst_to_the_next    <= BUBBLE_BUNDLE;
      rt_flag_to_the_next <= '0;
      ex_to_mem_ready     <= 1'b0;
    end else begin
      pc_to_the_next      <= pc;
      inst_to_the_next    <= inst;
      tdata               <= alu_res;
      rt_to_the_next      <= rt;
      rt_flag_to_the_next <= rt_flag;
      ex_to_mem_ready     <= |is_load;
    end
  end
`endif

endmodule

// File: tb/tb_exec_nlane.sv
// tb_exec_nlane: table-driven ALU vectors through a scoreboard, plus interlock, MUL and reset sequences.
module tb_exec_nlane;
  import exec_pkg::*;

  localparam int LANES = 2;
  localparam int XLEN  = 32;
  localparam int IW    = 32;
  localparam int RW    = 5;

  localparam logic [31:0] INST_ALU  = 32'h0000_0013;
  localparam logic [31:0] INST_LOAD = 32'h4000_0000;
  localparam logic [63:0] BUBBLE64  = 64'hE000_0000_E000_0000;

  logic                  clk = 1'b0;
  logic                  rstn, interlock, ex_busy, ex_to_mem_ready;
  logic [31:0]           pc, pc_to_the_next;
  logic [LANES*IW-1:0]   inst, inst_to_the_next;
  logic [LANES*XLEN-1:0] srca, srcb, tdata;
  logic [LANES*4-1:0]    e_type;
  logic [LANES*RW-1:0]   rt, rt_to_the_next;
  logic [LANES-1:0]      rt_flag, rt_flag_to_the_next;

  exec_nlane #(.LANES(LANES), .XLEN(XLEN), .IW(IW), .RW(RW)) dut (
    .clk                 (clk),
    .rstn                (rstn),
    .interlock           (interlock),
    .ex_busy             (ex_busy),
    .pc                  (pc),
    .inst                (inst),
    .srca                (srca),
    .srcb                (srcb),
    .e_type              (e_type),
    .rt                  (rt),
    .rt_flag             (rt_flag),
    .pc_to_the_next      (pc_to_the_next),
    .inst_to_the_next    (inst_to_the_next),
    .tdata               (tdata),
    .rt_to_the_next      (rt_to_the_next),
    .rt_flag_to_the_next (rt_flag_to_the_next),
    .ex_to_mem_ready     (ex_to_mem_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op0, op1;
    logic [31:0] a0, b0, a1, b1, i1;
    logic [1:0]  flg;
    logic [31:0] e0, e1;
    logic        mr;
  } vec_t;

  typedef struct {
    logic [63:0] td;
    logic [31:0] pc;
    logic [63:0] inst;
    logic [9:0]  rt;
    logic [1:0]  flg;
    logic        mr;
  } exp_t;

  vec_t        vecs[$];
  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [63:0] last_td;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op0, input logic [3:0] op1,
                       input logic [31:0] a0, input logic [31:0] b0,
                       input logic [31:0] a1, input logic [31:0] b1,
                       input logic [31:0] i1, input logic [1:0] flg, input logic [31:0] p,
                       input logic [63:0] exp_td, input logic exp_mr, input bit push);
    e_type    = {op1, op0};
    srca      = {a1, a0};
    srcb      = {b1, b0};
    inst      = {i1, INST_ALU};
    rt_flag   = flg;
    pc        = p;
    rt        = {p[11:7], p[6:2]};
    interlock = 1'b0;
    if (push) sb.push_back('{td: exp_td, pc: p, inst: {i1, INST_ALU}, rt: {p[11:7], p[6:2]},
                             flg: flg, mr: exp_mr});
  endtask

  task automatic compare_head(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = sb.pop_front();
    check({tag, ".tdata"}, tdata, e.td);
    check({tag, ".pc"}, {32'h0, pc_to_the_next}, {32'h0, e.pc});
    check({tag, ".inst"}, inst_to_the_next, e.inst);
    check({tag, ".rt"}, {54'h0, rt_to_the_next}, {54'h0, e.rt});
    check({tag, ".rt_flag"}, {62'h0, rt_flag_to_the_next}, {62'h0, e.flg});
    check({tag, ".mem_ready"}, {63'h0, ex_to_mem_ready}, {63'h0, e.mr});
    last_td = e.td;
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".tdata"}, tdata, 64'h0);
    check({tag, ".pc"}, {32'h0, pc_to_the_next}, 64'h0);
    check({tag, ".inst"}, inst_to_the_next, BUBBLE64);
    check({tag, ".rt"}, {54'h0, rt_to_the_next}, 64'h0);
    check({tag, ".rt_flag"}, {62'h0, rt_flag_to_the_next}, 64'h0);
    check({tag, ".mem_ready"}, {63'h0, ex_to_mem_ready}, 64'h0);
    check({tag, ".busy"}, {63'h0, ex_busy}, 64'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs.push_back('{OP_ADD, OP_SUB, 32'h7FFF_FFFF, 32'h1, 32'h0, 32'h1, INST_ALU, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0});
    vecs.push_back('{OP_SRA, OP_SRL, 32'h8000_0000, 32'h4, 32'h8000_0000, 32'h4, INST_ALU, 2'b10, 32'hF800_0000, 32'h0800_0000, 1'b0});
    vecs.push_back('{OP_SLT, OP_SLTU, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFF, 32'h1, INST_ALU, 2'b01, 32'h1, 32'h0, 1'b0});
    vecs.push_back('{OP_SLL, OP_SRL, 32'h1, 32'd33, 32'h8000_0000, 32'd33, INST_ALU, 2'b11, 32'h2, 32'h4000_0000, 1'b0});
    vecs.push_back('{OP_AND, OP_OR, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF0F0_F0F0, 32'hFF00_FF00, INST_ALU, 2'b11, 32'hF000_F000, 32'hFFF0_FFF0, 1'b0});
    vecs.push_back('{OP_XOR, OP_NOP, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h1, 32'h1234_5678, INST_ALU, 2'b00, 32'h0FF0_0FF0, 32'h1234_5678, 1'b0});
    vecs.push_back('{4'd12, 4'd15, 32'h1, 32'hAAAA_5555, 32'h2, 32'h5A5A, INST_ALU, 2'b11, 32'hAAAA_5555, 32'h5A5A, 1'b0});
    vecs.push_back('{OP_ADD, OP_ADD, 32'h5, 32'h6, 32'h1, 32'h2, INST_LOAD, 2'b01, 32'hB, 32'h3, 1'b1});
    vecs.push_back('{OP_SRA, OP_SUB, 32'h7FFF_FFF0, 32'h4, 32'h8000_0000, 32'h1, INST_ALU, 2'b10, 32'h07FF_FFFF, 32'h7FFF_FFFF, 1'b0});
    vecs.push_back('{OP_SLT, OP_SLTU, 32'hFFFF_FFFB, 32'hFFFF_FFFD, 32'h3, 32'hFFFF_FFFD, INST_ALU, 2'b11, 32'h1, 32'h1, 1'b0});
`ifndef EXEC_NLANE_MUL_EN
    vecs.push_back('{OP_MUL, OP_MUL, 32'h5, 32'h9, 32'h7, 32'h0BAD_F00D, INST_ALU, 2'b11, 32'h9, 32'h0BAD_F00D, 1'b0});
`endif

    rstn = 1'b0;
    drive(OP_ADD, OP_ADD, 32'h1, 32'h2, 32'h3, 32'h4, INST_LOAD, 2'b11, 32'h40, 64'h0, 1'b0, 0);
    repeat (3) @(negedge clk);
    check_reset("reset");
    rstn = 1'b1;
    interlock = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      if (i > 0) compare_head($sformatf("vec%0d", i - 1));
      drive(vecs[i].op0, vecs[i].op1, vecs[i].a0, vecs[i].b0, vecs[i].a1, vecs[i].b1, vecs[i].i1,
            vecs[i].flg, 32'h1000 + 32'(4 * i), {vecs[i].e1, vecs[i].e0}, vecs[i].mr, 1);
    end
    @(negedge clk);
    compare_head($sformatf("vec%0d", vecs.size() - 1));

    // Valid load bundle under interlock must leave as a bubble with tdata held.
    drive(OP_ADD, OP_ADD, 32'h1, 32'h1, 32'h1, 32'h1, INST_LOAD, 2'b11, 32'h3000, 64'h0, 1'b0, 0);
    interlock = 1'b1;
    @(negedge clk);
    check("intl.pc", {32'h0, pc_to_the_next}, 64'h0);
    check("intl.inst", inst_to_the_next, BUBBLE64);
    check("intl.rt_flag", {62'h0, rt_flag_to_the_next}, 64'h0);
    check("intl.mem_ready", {63'h0, ex_to_mem_ready}, 64'h0);
    check("intl.tdata_hold", tdata, last_td);

`ifdef EXEC_NLANE_MUL_EN
    drive(OP_MUL, OP_ADD, 32'h0001_2345, 32'h100, 32'h3, 32'h4, INST_ALU, 2'b11, 32'h2000,
          {32'h7, 32'h0123_4500}, 1'b0, 1);
    for (int c = 0; c < XLEN; c++) begin
      @(negedge clk);
      check($sformatf("mul.busy%0d", c), {63'h0, ex_busy}, 64'h1);
      check($sformatf("mul.bubble%0d", c), {62'h0, rt_flag_to_the_next}, 64'h0);
      if (c == 0) begin
        check("mul.pc_bubble", {32'h0, pc_to_the_next}, 64'h0);
        check("mul.tdata_hold", tdata, last_td);
      end
      // Inputs during MUL are noise and must be ignored.
      drive(OP_ADD, OP_SUB, $urandom, $urandom, $urandom, $urandom, INST_LOAD, 2'b11, $urandom, 64'h0, 1'b0, 0);
      interlock = c[0];
    end
    @(negedge clk);
    check("mul.busy_end", {63'h0, ex_busy}, 64'h0);
    compare_head("mul");
    drive(OP_ADD, OP_XOR, 32'h10, 32'h20, 32'hFF, 32'h0F, INST_ALU, 2'b10, 32'h2100, {32'hF0, 32'h30}, 1'b0, 1);
    @(negedge clk);
    compare_head("post_mul");

    drive(OP_MUL, OP_MUL, 32'h3, 32'h5, 32'h7, 32'h9, INST_ALU, 2'b11, 32'h2200, 64'h0, 1'b0, 0);
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      check($sformatf("rmul.busy%0d", c), {63'h0, ex_busy}, 64'h1);
    end
`else
    drive(OP_ADD, OP_ADD, 32'h3, 32'h5, 32'h7, 32'h9, INST_ALU, 2'b11, 32'h2200, {32'h10, 32'h8}, 1'b0, 1);
    @(negedge clk);
    compare_head("pre_reset");
`endif
    rstn = 1'b0;
    @(negedge clk);
    check_reset("mid_reset");
    rstn = 1'b1;
    drive(OP_ADD, OP_ADD, 32'h20, 32'h22, 32'h1, 32'hFFFF_FFFF, INST_ALU, 2'b01, 32'h2300, {32'h0, 32'h42}, 1'b0, 1);
    @(negedge clk);
    compare_head("post_reset");
    check("post_reset.busy", {63'h0, ex_busy}, 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
